fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential restoring-division floating-point divider
// Optional build macro: FP_DIV_RNE_EN (round-to-nearest-even; truncation otherwise)
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   C,
  output logic                   ready,
  output logic                   valid,
  output logic                   div_by_zero
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int CNT_W  = $clog2(MAN_W + 3);
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;
  localparam logic signed [EXP_W+1:0] BIAS = BIAS_I[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] EMAX = EMAX_I[EXP_W+1:0];
  localparam logic signed [EXP_W+1:0] ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(MAN_W + 2);

`ifdef FP_DIV_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;

  state_t                  state;
  logic [W-1:0]            a_r;
  logic [W-1:0]            b_r;
  logic signed [EXP_W+1:0] exp_r;
  logic [MAN_W:0]          mb_r;
  logic [MAN_W+1:0]        rem;
  logic [MAN_W+2:0]        quo;
  logic                    sticky;
  logic [CNT_W-1:0]        cnt;
  logic                    spec;
  logic [W-1:0]            res;
  logic                    res_dbz;

  // operand fields; exponent zero means zero or denormal, both treated as zero
  logic               sa, sb, sgn;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               za, zb, ia, ib, na, nb;

  assign sa  = a_r[W-1];
  assign sb  = b_r[W-1];
  assign sgn = sa ^ sb;
  assign ea  = a_r[W-2:MAN_W];
  assign eb  = b_r[W-2:MAN_W];
  assign fa  = a_r[MAN_W-1:0];
  assign fb  = b_r[MAN_W-1:0];
  assign za  = (ea == '0);
  assign zb  = (eb == '0);
  assign ia  = (ea == '1) && (fa == '0);
  assign ib  = (eb == '1) && (fb == '0);
  assign na  = (ea == '1) && (fa != '0);
  assign nb  = (eb == '1) && (fb != '0);

  logic [W-1:0] zero_v, inf_v, qnan_v;
  assign zero_v = {sgn, {(W-1){1'b0}}};
  assign inf_v  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign qnan_v = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // special-operand classification, priority NaN > inf dividend > zero divisor > zero > inf divisor
  logic         is_spec;
  logic [W-1:0] spec_res;
  logic         spec_dbz;
  always_comb begin
    is_spec  = 1'b1;
    spec_dbz = 1'b0;
    spec_res = zero_v;
    if (na || nb || (za && zb) || (ia && ib)) begin
      spec_res = qnan_v;
    end else if (ia) begin
      spec_res = inf_v;
    end else if (zb) begin
      spec_res = inf_v;
      spec_dbz = 1'b1;
    end else if (za || ib) begin
      spec_res = zero_v;
    end else begin
      is_spec = 1'b0;
    end
  end

  // one restoring-division step: subtract divisor when it fits
  logic             q_bit;
  logic [MAN_W+1:0] rem_n;
  always_comb begin
    q_bit = (rem >= {1'b0, mb_r});
    rem_n = q_bit ? (rem - {1'b0, mb_r}) : rem;
  end

  // rounding, exponent adjustment and overflow/underflow packing of the normalised quotient
  logic [MAN_W:0]          mant;
  logic                    grd, rnd, inc, carry;
  logic [MAN_W+1:0]        sum;
  logic signed [EXP_W+1:0] e_f;
  logic [MAN_W-1:0]        frac;
  logic [W-1:0]            rnd_res;
  always_comb begin
    mant  = quo[MAN_W+2:2];
    grd   = quo[1];
    rnd   = quo[0];
    inc   = RNE & grd & (rnd | sticky | mant[0]);
    sum   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    carry = sum[MAN_W+1];
    e_f   = exp_r + $signed({{(EXP_W+1){1'b0}}, carry});
    frac  = carry ? '0 : sum[MAN_W-1:0];
    if (!(carry || sum[MAN_W]) || (e_f <= 0)) begin
      rnd_res = zero_v;
    end else if (e_f >= EMAX) begin
      rnd_res = inf_v;
    end else begin
      rnd_res = {sgn, e_f[EXP_W-1:0], frac};
    end
  end

  // control FSM with registered outputs; special results publish from DONE, normal ones on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      exp_r       <= '0;
      mb_r        <= '0;
      rem         <= '0;
      quo         <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      spec        <= 1'b0;
      res         <= '0;
      res_dbz     <= 1'b0;
      C           <= '0;
      ready       <= 1'b1;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            ready <= 1'b0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          exp_r   <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          rem     <= {1'b0, 1'b1, fa};
          mb_r    <= {1'b1, fb};
          quo     <= '0;
          sticky  <= 1'b0;
          cnt     <= '0;
          spec    <= is_spec;
          res     <= spec_res;
          res_dbz <= spec_dbz;
          state   <= is_spec ? DONE : DIVIDE;
        end
        DIVIDE: begin
          quo <= {quo[MAN_W+1:0], q_bit};
          rem <= {rem_n[MAN_W:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            sticky <= (rem_n != '0);
            state  <= NORM;
          end
        end
        NORM: begin
          if (!quo[MAN_W+2]) begin
            quo   <= {quo[MAN_W+1:0], 1'b0};
            exp_r <= exp_r - ONE;
          end
          state <= ROUND;
        end
        ROUND: begin
          C           <= rnd_res;
          div_by_zero <= 1'b0;
          valid       <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (spec) begin
            C           <= res;
            div_by_zero <= res_dbz;
            valid       <= 1'b1;
          end
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;
  logic        ready;
  logic        valid;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .C(C), .ready(ready), .valid(valid), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // one complete operation: latency, result, flag, single-cycle pulse, ready return
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_c, input logic exp_dbz);
    int n;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 32'hDEADBEEF; B = 32'h12345678;
    check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
    n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (valid) seen = 1;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_C"}, C, exp_c);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int n;
    int pulses;
    int first;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_C", C, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("div3_2",    32'h40400000, 32'h40000000, 29, 32'h3FC00000, 1'b0);
    run_op("div1_3",    32'h3F800000, 32'h40400000, 29, THIRD,         1'b0);
    run_op("divneg6_2", 32'hC0C00000, 32'h40000000, 29, 32'hC0400000, 1'b0);
    run_op("div1_1",    32'h3F800000, 32'h3F800000, 29, 32'h3F800000, 1'b0);
    run_op("x_by_0",    32'h3F800000, 32'h00000000, 2,  32'h7F800000, 1'b1);
    run_op("after_dbz", 32'h40400000, 32'h40000000, 29, 32'h3FC00000, 1'b0);
    run_op("negx_by_0", 32'hBF800000, 32'h00000000, 2,  32'hFF800000, 1'b1);
    run_op("zero_by_x", 32'h00000000, 32'h40A00000, 2,  32'h00000000, 1'b0);
    run_op("nan_in",    32'h7FC00000, 32'h3F800000, 2,  32'h7FC00000, 1'b0);
    run_op("inf_inf",   32'h7F800000, 32'hFF800000, 2,  32'h7FC00000, 1'b0);
    run_op("x_by_inf",  32'h40000000, 32'hFF800000, 2,  32'h80000000, 1'b0);
    run_op("denorm_in", 32'h00400000, 32'h3F800000, 2,  32'h00000000, 1'b0);
    run_op("overflow",  32'h7F000000, 32'h3E800000, 29, 32'h7F800000, 1'b0);
    run_op("underflow", 32'h80800000, 32'h40000000, 29, 32'h80000000, 1'b0);

    // second start five cycles into an operation must be dropped
    @(negedge clk);
    A = 32'h40400000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 32'h3F800000; B = 32'h40400000;
    repeat (4) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; first = 0;
    for (int i = 6; i <= 45; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_latency", first, 29);
    check("ignore_C", C, 32'h3FC00000);

    // reset in the middle of a divide
    @(negedge clk);
    A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_C", C, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    run_op("post_rst", 32'h40400000, 32'h40000000, 29, 32'h3FC00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
